// File: rtl/dff_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dff_pipe_pkg
//
// Purpose : Shared constants and types for the dff_pipe register pipeline.
//           Holds the default data width and stage count, the stage record
//           (valid bit plus data word) for the default width, and a helper
//           that sizes the optional occupancy counter.
//
// Contents:
//   DFF_PIPE_WIDTH_DEFAULT  default data width in bits
//   DFF_PIPE_DEPTH_DEFAULT  default number of register stages
//   dff_pipe_stage_t        stage record {valid, data} at the default width
//   occ_width()             bits needed to count 0..depth valid stages
//
// Configuration macro used by the top level: DFF_PIPE_OCCUPANCY_EN
// -----------------------------------------------------------------------------
package dff_pipe_pkg;

   localparam int unsigned DFF_PIPE_WIDTH_DEFAULT = 16;
   localparam int unsigned DFF_PIPE_DEPTH_DEFAULT = 2;

   // One pipeline stage as seen from outside: the word and whether it is live.
   typedef struct packed {
      logic                              valid;
      logic [DFF_PIPE_WIDTH_DEFAULT-1:0] data;
   } dff_pipe_stage_t;

   // Width of a counter that must represent every value 0..depth inclusive.
   function automatic int unsigned occ_width(input int unsigned depth);
      int unsigned w;
      w = $clog2(depth + 1);
      if (w == 0) begin
         w = 1;
      end
      return w;
   endfunction

endpackage : dff_pipe_pkg

// File: rtl/dff_pipe_stage.sv
// -----------------------------------------------------------------------------
// dff_pipe_stage
//
// Purpose : One stage of the dff_pipe pipeline: a valid flag and a
//           load-enabled data register. The data register only changes when
//           a word is written into the stage, so it keeps stale contents
//           after the word has moved on or been flushed.
//
// Ports:
//   clk_i    clock, all state changes on its rising edge
//   srst_i   synchronous active-high reset (valid cleared, data = RESET_VALUE)
//   clear_i  synchronous clear of the valid flag only (flush)
//   fill_i   a word is written into this stage at this edge
//   drain_i  the word held here moves downstream / out at this edge
//   data_i   word to write when fill_i is high
//   valid_o  stage holds a live word
//   data_o   data register contents
// -----------------------------------------------------------------------------
module dff_pipe_stage
   import dff_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH       = DFF_PIPE_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             clear_i,
   input  logic             fill_i,
   input  logic             drain_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // A stage that is filled and drained at the same edge stays valid: the
   // old word leaves and the new one takes its place.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (fill_i) begin
         valid_d = 1'b1;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
      // Data is untouched by a clear; only a real write moves it.
      if (fill_i && !clear_i) begin
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         valid_q <= 1'b0;
         data_q  <= RESET_VALUE;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : dff_pipe_stage

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
//
// Purpose : Elastic register pipeline of DEPTH stages with valid/ready
//           handshakes on both ends. Words move forward whenever the next
//           stage is empty or is itself moving, so bubbles collapse and the
//           pipe holds exactly DEPTH words under backpressure. A word
//           entering an empty, unstalled pipe reaches Q DEPTH-1 edges after
//           it was accepted.
//
// Parameters:
//   WIDTH        data width in bits (>= 1)
//   DEPTH        number of register stages (>= 1)
//   RESET_VALUE  value loaded into every data register on reset
//
// Ports:
//   CLOCK      in   sole clock, rising edge
//   RESET      in   synchronous active-high reset, highest priority
//   FLUSH      in   synchronous clear of all valid bits, blocks input
//   IN_VALID   in   D holds a word to be accepted
//   IN_READY   out  pipe can accept D at this edge
//   D          in   input data
//   OUT_VALID  out  Q holds a valid word
//   OUT_READY  in   consumer takes Q at this edge
//   Q          out  data of the last stage
//   OCCUPANCY  out  number of valid stages (only with DFF_PIPE_OCCUPANCY_EN)
//
// Configuration: define DFF_PIPE_OCCUPANCY_EN to add the OCCUPANCY port and
// its registered counter. Without it the port and counter do not exist.
// -----------------------------------------------------------------------------
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH       = DFF_PIPE_WIDTH_DEFAULT,
   parameter int unsigned      DEPTH       = DFF_PIPE_DEPTH_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] D,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] Q
`ifdef DFF_PIPE_OCCUPANCY_EN
   ,
   output logic [occ_width(DEPTH)-1:0] OCCUPANCY
`endif
);

   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] stage_adv;
   logic [DEPTH-1:0] stage_fill;
   logic [WIDTH-1:0] stage_data [DEPTH];
   logic             accept;

   // Input side: stage 0 has room if it is empty or its word is moving on.
   assign IN_READY = (~stage_valid[0] | stage_adv[0]) & ~FLUSH & ~RESET;
   assign accept   = IN_VALID & IN_READY;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         // Advance chain, evaluated from the output end backwards in the
         // same cycle so a full pipe can move as a whole when drained.
         if (gi == DEPTH - 1) begin : g_adv_last
            assign stage_adv[gi] = stage_valid[gi] & OUT_READY;
         end else begin : g_adv_mid
            assign stage_adv[gi] = stage_valid[gi]
                                 & (~stage_valid[gi+1] | stage_adv[gi+1]);
         end

         // A stage is written by the input handshake (stage 0) or by its
         // upstream neighbour advancing. A flush freezes all data, so the
         // inter-stage writes are suppressed along with the valid bits.
         if (gi == 0) begin : g_fill_first
            assign stage_fill[gi] = accept;
         end else begin : g_fill_next
            assign stage_fill[gi] = stage_adv[gi-1] & ~FLUSH;
         end

         logic [WIDTH-1:0] stage_din;
         if (gi == 0) begin : g_din_first
            assign stage_din = D;
         end else begin : g_din_next
            assign stage_din = stage_data[gi-1];
         end

         dff_pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_stage (
            .clk_i   (CLOCK),
            .srst_i  (RESET),
            .clear_i (FLUSH),
            .fill_i  (stage_fill[gi]),
            .drain_i (stage_adv[gi]),
            .data_i  (stage_din),
            .valid_o (stage_valid[gi]),
            .data_o  (stage_data[gi])
         );
      end
   endgenerate

   assign OUT_VALID = stage_valid[DEPTH-1];
   assign Q         = stage_data[DEPTH-1];

`ifdef DFF_PIPE_OCCUPANCY_EN
   localparam int unsigned OCC_W = occ_width(DEPTH);

   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic             take;

   // A word leaves only when the last stage advances; a flush overrides it.
   assign take = stage_adv[DEPTH-1] & ~FLUSH;

   always_comb begin
      occ_d = occ_q;
      if (FLUSH) begin
         occ_d = '0;
      end else begin
         unique case ({accept, take})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign OCCUPANCY = occ_q;
`endif

endmodule : dff_pipe

// File: tb/tb_dff_pipe.sv
// -----------------------------------------------------------------------------
// tb_dff_pipe
//
// Self-checking bench for dff_pipe with WIDTH=16, DEPTH=3. Accepted words are
// pushed into a scoreboard queue and popped/compared when the pipe hands a
// word out. Scenario tasks add their own direct checks on latency, ready,
// occupancy and flush/reset behaviour. OCCUPANCY checks exist only when
// DFF_PIPE_OCCUPANCY_EN is defined.
// -----------------------------------------------------------------------------
module tb_dff_pipe;
   import dff_pipe_pkg::*;

   localparam int WIDTH = 16;
   localparam int DEPTH = 3;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             CLOCK     = 1'b0;
   logic             RESET     = 1'b1;
   logic             FLUSH     = 1'b0;
   logic             IN_VALID  = 1'b0;
   logic             OUT_READY = 1'b0;
   logic [WIDTH-1:0] D         = '0;
   logic             IN_READY;
   logic             OUT_VALID;
   logic [WIDTH-1:0] Q;
`ifdef DFF_PIPE_OCCUPANCY_EN
   logic [OCC_W-1:0] OCCUPANCY;
`endif

   int checks   = 0;
   int failures = 0;

   dff_pipe_stage_t sb[$];

   always #5 CLOCK = ~CLOCK;

   dff_pipe #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .RESET_VALUE (16'h0000)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .FLUSH     (FLUSH),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .D         (D),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .Q         (Q)
`ifdef DFF_PIPE_OCCUPANCY_EN
      ,
      .OCCUPANCY (OCCUPANCY)
`endif
   );

   // Scoreboard: at the falling edge the inputs and outputs are stable and
   // describe exactly what the next rising edge will do.
   always @(negedge CLOCK) begin
      dff_pipe_stage_t rec;
      if (RESET) begin
         sb.delete();
      end else begin
`ifdef DFF_PIPE_OCCUPANCY_EN
         checks++;
         if (OCCUPANCY !== OC_W_CAST(sb.size())) begin
            failures++;
            $display("FAIL sb_occupancy got=%0d exp=%0d", OCCUPANCY, sb.size());
         end
`endif
         if (FLUSH) begin
            sb.delete();
         end else begin
            if (OUT_VALID && OUT_READY) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL sb_unexpected got=%h exp=<no word>", Q);
               end else begin
                  rec = sb.pop_front();
                  if (Q !== rec.data) begin
                     failures++;
                     $display("FAIL sb_order got=%h exp=%h", Q, rec.data);
                  end else begin
                     $display("out  Q=%h", Q);
                  end
               end
            end
            if (IN_VALID && IN_READY) begin
               rec.valid = 1'b1;
               rec.data  = D;
               sb.push_back(rec);
               $display("in   D=%h", D);
            end
         end
      end
   end

   function automatic logic [OCC_W-1:0] OC_W_CAST(input int n);
      return OCC_W'(n);
   endfunction

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      step();
      step();
      checks++;
      if (OUT_VALID !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID);
      end
      checks++;
      if (Q !== 16'h0000) begin
         failures++; $display("FAIL reset_q got=%h exp=0000", Q);
      end
      checks++;
      if (IN_READY !== 1'b0) begin
         failures++; $display("FAIL reset_in_ready_during got=%b exp=0", IN_READY);
      end
`ifdef DFF_PIPE_OCCUPANCY_EN
      checks++;
      if (OCCUPANCY !== '0) begin
         failures++; $display("FAIL reset_occupancy got=%0d exp=0", OCCUPANCY);
      end
`endif
      RESET = 1'b0;
      #1;
      checks++;
      if (IN_READY !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready_after got=%b exp=1", IN_READY);
      end
   endtask

   task automatic test_stream();
      logic [WIDTH-1:0] vals [3];
      vals[0] = 16'h8000; vals[1] = 16'h0001; vals[2] = 16'h1234;
      OUT_READY = 1'b1;
      for (int k = 0; k < 3; k++) begin
         IN_VALID = 1'b1;
         D        = vals[k];
         step();
         if (k < 2) begin
            checks++;
            if (OUT_VALID !== 1'b0) begin
               failures++; $display("FAIL stream_early_valid got=%b exp=0", OUT_VALID);
            end
         end
      end
      IN_VALID = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (OUT_VALID !== 1'b1 || Q !== vals[k]) begin
            failures++;
            $display("FAIL stream_word%0d got=%b/%h exp=1/%h", k, OUT_VALID, Q, vals[k]);
         end
         step();
      end
      checks++;
      if (OUT_VALID !== 1'b0) begin
         failures++; $display("FAIL stream_end_valid got=%b exp=0", OUT_VALID);
      end
   endtask

   task automatic test_backpressure();
      OUT_READY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         IN_VALID = 1'b1;
         D        = 16'hA001 + 16'(k);
         #1;
         checks++;
         if (IN_READY !== 1'b1) begin
            failures++; $display("FAIL bp_accept%0d got=%b exp=1", k, IN_READY);
         end
         step();
      end
      D = 16'hA004;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (IN_READY !== 1'b0 || Q !== 16'hA001 || OUT_VALID !== 1'b1) begin
            failures++;
            $display("FAIL bp_full%0d got=rdy %b q %h v %b exp=rdy 0 q a001 v 1",
                     k, IN_READY, Q, OUT_VALID);
         end
`ifdef DFF_PIPE_OCCUPANCY_EN
         checks++;
         if (OCCUPANCY !== 2'd3) begin
            failures++; $display("FAIL bp_occupancy got=%0d exp=3", OCCUPANCY);
         end
`endif
         if (k == 0) step();
      end
      OUT_READY = 1'b1;
      #1;
      checks++;
      if (IN_READY !== 1'b1) begin
         failures++; $display("FAIL bp_release_ready got=%b exp=1", IN_READY);
      end
      step();
      IN_VALID = 1'b0;
      #1;
      checks++;
      if (Q !== 16'hA002 || OUT_VALID !== 1'b1) begin
         failures++; $display("FAIL bp_swap got=%h exp=a002", Q);
      end
`ifdef DFF_PIPE_OCCUPANCY_EN
      checks++;
      if (OCCUPANCY !== 2'd3) begin
         failures++; $display("FAIL bp_swap_occupancy got=%0d exp=3", OCCUPANCY);
      end
`endif
      step();
      step();
      checks++;
      if (Q !== 16'hA004 || OUT_VALID !== 1'b1) begin
         failures++; $display("FAIL bp_last got=%h exp=a004", Q);
      end
      step();
      checks++;
      if (OUT_VALID !== 1'b0) begin
         failures++; $display("FAIL bp_drained got=%b exp=0", OUT_VALID);
      end
   endtask

   task automatic test_bubble();
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      D         = 16'hAAAA;
      step();
      IN_VALID = 1'b0;
      step();
      step();
      IN_VALID = 1'b1;
      D        = 16'hBBBB;
      step();
      IN_VALID = 1'b0;
      step();
      #1;
      checks++;
      if (Q !== 16'hAAAA || OUT_VALID !== 1'b1) begin
         failures++; $display("FAIL bubble_stage2 got=%b/%h exp=1/aaaa", OUT_VALID, Q);
      end
      checks++;
      if (dut.g_stage[1].u_stage.valid_o !== 1'b1 ||
          dut.g_stage[1].u_stage.data_o !== 16'hBBBB) begin
         failures++;
         $display("FAIL bubble_stage1 got=%b/%h exp=1/bbbb",
                  dut.g_stage[1].u_stage.valid_o, dut.g_stage[1].u_stage.data_o);
      end
      checks++;
      if (IN_READY !== 1'b1) begin
         failures++; $display("FAIL bubble_ready got=%b exp=1", IN_READY);
      end
`ifdef DFF_PIPE_OCCUPANCY_EN
      checks++;
      if (OCCUPANCY !== 2'd2) begin
         failures++; $display("FAIL bubble_occupancy got=%0d exp=2", OCCUPANCY);
      end
`endif
      OUT_READY = 1'b1;
      step();
      checks++;
      if (Q !== 16'hBBBB || OUT_VALID !== 1'b1) begin
         failures++; $display("FAIL bubble_second got=%b/%h exp=1/bbbb", OUT_VALID, Q);
      end
      step();
   endtask

   task automatic test_flush();
      OUT_READY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         IN_VALID = 1'b1;
         D        = 16'h1111 * 16'(k + 1);
         step();
      end
      FLUSH    = 1'b1;
      IN_VALID = 1'b1;
      D        = 16'hCCCC;
      #1;
      checks++;
      if (IN_READY !== 1'b0) begin
         failures++; $display("FAIL flush_ready got=%b exp=0", IN_READY);
      end
      step();
      FLUSH     = 1'b0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      #1;
      checks++;
      if (OUT_VALID !== 1'b0) begin
         failures++; $display("FAIL flush_valid got=%b exp=0", OUT_VALID);
      end
      checks++;
      if (Q !== 16'h1111) begin
         failures++; $display("FAIL flush_data_kept got=%h exp=1111", Q);
      end
`ifdef DFF_PIPE_OCCUPANCY_EN
      checks++;
      if (OCCUPANCY !== '0) begin
         failures++; $display("FAIL flush_occupancy got=%0d exp=0", OCCUPANCY);
      end
`endif
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (OUT_VALID !== 1'b0) begin
            failures++; $display("FAIL flush_no_output%0d got=%b/%h exp=0", k, OUT_VALID, Q);
         end
      end
   endtask

   task automatic test_reset_flush();
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      D         = 16'h5555;
      step();
      D = 16'h6666;
      step();
      IN_VALID = 1'b0;
      step();
      checks++;
      if (Q !== 16'h5555 || OUT_VALID !== 1'b1) begin
         failures++; $display("FAIL rf_held got=%b/%h exp=1/5555", OUT_VALID, Q);
      end
      RESET    = 1'b1;
      FLUSH    = 1'b1;
      IN_VALID = 1'b1;
      D        = 16'h7777;
      step();
      RESET     = 1'b0;
      FLUSH     = 1'b0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      #1;
      checks++;
      if (Q !== 16'h0000 || OUT_VALID !== 1'b0) begin
         failures++; $display("FAIL rf_cleared got=%b/%h exp=0/0000", OUT_VALID, Q);
      end
      checks++;
      if (IN_READY !== 1'b1) begin
         failures++; $display("FAIL rf_ready got=%b exp=1", IN_READY);
      end
`ifdef DFF_PIPE_OCCUPANCY_EN
      checks++;
      if (OCCUPANCY !== '0) begin
         failures++; $display("FAIL rf_occupancy got=%0d exp=0", OCCUPANCY);
      end
`endif
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (OUT_VALID !== 1'b0) begin
            failures++; $display("FAIL rf_no_output%0d got=%b/%h exp=0", k, OUT_VALID, Q);
         end
      end
   endtask

   task automatic test_back_to_back();
      int budget;
      // Full-rate streaming: ready must never drop.
      OUT_READY = 1'b1;
      for (int k = 0; k < 8; k++) begin
         IN_VALID = 1'b1;
         D        = 16'(16'h0100 + k);
         #1;
         checks++;
         if (IN_READY !== 1'b1) begin
            failures++; $display("FAIL b2b_rate%0d got=%b exp=1", k, IN_READY);
         end
         step();
      end
      // Random valid / backpressure mix; ordering checked by the scoreboard.
      for (int k = 0; k < 150; k++) begin
         IN_VALID  = 1'($urandom_range(0, 1));
         OUT_READY = ($urandom_range(0, 3) != 0);
         D         = 16'($urandom);
         step();
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      budget    = 0;
      while ((sb.size() != 0 || OUT_VALID) && budget < 20) begin
         step();
         budget++;
      end
      checks++;
      if (sb.size() != 0 || OUT_VALID !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain got=%0d pending exp=0 pending", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble();
      test_flush();
      test_reset_flush();
      test_back_to_back();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_dff_pipe
